// File: rtl/fifo_4b_valid_pkg.sv
// Sizing constants and the word type shared by the FIFO top and its storage array.
`include "fifo_4b_defines.sv"

package fifo_4b_valid_pkg;

    localparam int DATA_W      = 4;
    localparam int DEPTH       = `FIFO_4B_DEPTH;
    localparam int ADDR_W      = $clog2(DEPTH);
    localparam int COUNT_W     = ADDR_W + 1;
    localparam int ALMOST_FULL = `FIFO_4B_ALMOST_FULL;

    typedef logic [DATA_W-1:0]  word_t;
    typedef logic [ADDR_W-1:0]  ptr_t;
    typedef logic [COUNT_W-1:0] count_t;

    // Pointers are exactly ADDR_W bits wide, so a plain increment wraps DEPTH-1 to 0.
    function automatic ptr_t ptrInc(input ptr_t p);
        return p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_4b_defines.sv
// Shared build-time defaults for the 4-bit valid FIFO.
// The mux bench and the FIFO pick up the same values from this file.
`ifndef FIFO_4B_DEFINES_SV
`define FIFO_4B_DEFINES_SV

`ifndef FIFO_4B_DEPTH
`define FIFO_4B_DEPTH 4
`endif

`ifndef FIFO_4B_ALMOST_FULL
`define FIFO_4B_ALMOST_FULL 3
`endif

`endif

// File: rtl/fifo_4b_valid_mem.sv
// DEPTH x DATA_W register array: one write port and one registered read port.
module fifo_mem_4b
    import fifo_4b_valid_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  wr_en_i,
    input  ptr_t  wr_addr_i,
    input  word_t wr_data_i,
    input  logic  rd_en_i,
    input  ptr_t  rd_addr_i,
    output word_t rd_data_o
);

    word_t mem_q [DEPTH];
    word_t rd_data_q;

    // Storage is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // A read of the slot being written this cycle returns the older word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_4b_valid.sv
// Valid-gated 4-bit FIFO: pointers, occupancy count, handshake, flags and sticky errors.
module fifo_4b_valid
    import fifo_4b_valid_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DATA_W-1:0]  in_data_i,
    input  logic               in_valid_i,
    input  logic               pop_i,
    output logic [DATA_W-1:0]  out_data_o,
    output logic               out_valid_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               almost_full_o,
    output logic [COUNT_W-1:0] count_o,
    output logic               overflow_err_o,
    output logic               underflow_err_o
);

    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    count_t count_q,  count_d;
    logic   out_valid_q, out_valid_d;
    logic   overflow_q,  overflow_d;
    logic   underflow_q, underflow_d;

    logic   pop_ok;
    logic   push_ok;

    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == count_t'(DEPTH));
    assign almost_full_o = (count_q >= count_t'(ALMOST_FULL));

    // A full FIFO still accepts a push when a word leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = in_valid_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + count_t'(push_ok) - count_t'(pop_ok);
        out_valid_d = pop_ok;
        overflow_d  = overflow_q  | (in_valid_i & ~push_ok);
        underflow_d = underflow_q | (pop_i & empty_o);
        if (push_ok) begin
            wr_ptr_d = ptrInc(wr_ptr_q);
        end
        if (pop_ok) begin
            rd_ptr_d = ptrInc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_4b u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (push_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data_i),
        .rd_en_i   (pop_ok),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (out_data_o)
    );

    assign out_valid_o     = out_valid_q;
    assign count_o         = count_q;
    assign overflow_err_o  = overflow_q;
    assign underflow_err_o = underflow_q;

endmodule

// File: tb/tb_fifo_4b_valid.sv
// Scoreboard bench for fifo_4b_valid against a queue-based reference model.
module tb_fifo_4b_valid;

    logic       clk;
    logic       rst_n;
    logic [3:0] inData;
    logic       inValid;
    logic       pop;
    logic [3:0] outData;
    logic       outValid;
    logic       full;
    logic       empty;
    logic       almostFull;
    logic [2:0] count;
    logic       overflowErr;
    logic       underflowErr;

    int checks   = 0;
    int failures = 0;

    logic [3:0] modelQ [$];
    logic [3:0] sbQ    [$];
    logic       modelOvf;
    logic       modelUnf;
    logic       expValid;
    logic [3:0] lastOut;

    fifo_4b_valid dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data_i       (inData),
        .in_valid_i      (inValid),
        .pop_i           (pop),
        .out_data_o      (outData),
        .out_valid_o     (outValid),
        .full_o          (full),
        .empty_o         (empty),
        .almost_full_o   (almostFull),
        .count_o         (count),
        .overflow_err_o  (overflowErr),
        .underflow_err_o (underflowErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkFlags();
        int n;
        n = modelQ.size();
        checkOutput("count", int'(count), n);
        checkOutput("empty", int'(empty), int'(n == 0));
        checkOutput("full", int'(full), int'(n == 4));
        checkOutput("almost_full", int'(almostFull), int'(n >= 3));
        checkOutput("overflow_err", int'(overflowErr), int'(modelOvf));
        checkOutput("underflow_err", int'(underflowErr), int'(modelUnf));
        checkOutput("out_valid", int'(outValid), int'(expValid));
        if (!expValid) checkOutput("out_data_hold", int'(outData), int'(lastOut));
    endtask

    // One clock of stimulus; the model decides what the FIFO must do this cycle.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic p);
        logic mEmpty, mFull, popOk, pushOk;
        logic [3:0] w;
        mEmpty = (modelQ.size() == 0);
        mFull  = (modelQ.size() == 4);
        popOk  = p && !mEmpty;
        pushOk = v && (!mFull || popOk);
        expValid = popOk;
        if (popOk) begin
            w = modelQ.pop_front();
            sbQ.push_back(w);
            lastOut = w;
        end
        if (pushOk) modelQ.push_back(d);
        if (v && !pushOk) modelOvf = 1'b1;
        if (p && mEmpty)  modelUnf = 1'b1;
        inValid = v;
        inData  = d;
        pop     = p;
        @(negedge clk);
        #1;
        checkFlags();
    endtask

    task automatic doReset();
        inValid = 1'b0;
        pop     = 1'b0;
        inData  = 4'h0;
        rst_n   = 1'b0;
        modelQ.delete();
        sbQ.delete();
        modelOvf = 1'b0;
        modelUnf = 1'b0;
        expValid = 1'b0;
        lastOut  = 4'h0;
        #13;
        checkOutput("reset_out_data", int'(outData), 0);
        checkFlags();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    function automatic logic [4:0] muxOut(input logic sel, input logic [3:0] d0, input logic v0,
                                          input logic [3:0] d1, input logic v1);
        return sel ? {v1, d1} : {v0, d0};
    endfunction

    // Pops one expected word whenever the DUT presents output.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && outValid) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                end else begin
                    logic [3:0] e;
                    e = sbQ.pop_front();
                    checkOutput("out_data", int'(outData), int'(e));
                end
            end
        end
    end

    initial begin
        logic [4:0] m;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        doReset();

        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 4'(i), 1'b0);
        applyStimulus(1'b1, 4'h5, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'h0, 1'b1);
        applyStimulus(1'b1, 4'h6, 1'b0);
        applyStimulus(1'b1, 4'h7, 1'b0);
        applyStimulus(1'b1, 4'hA, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0, 1'b1);
        applyStimulus(1'b1, 4'h9, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b1);

        // Mid-stream reset, then a clean underflow and a wrapping stream at low occupancy.
        applyStimulus(1'b1, 4'h3, 1'b0);
        applyStimulus(1'b1, 4'h4, 1'b0);
        doReset();
        applyStimulus(1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 4'(i + 3), (i > 0));
        applyStimulus(1'b0, 4'h0, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b1);

        doReset();
        for (int i = 0; i < 4; i++) begin
            m = muxOut(i >= 2, 4'(i + 1), 1'b1, 4'(i + 8), 1'b1);
            applyStimulus(m[4], m[3:0], 1'b0);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 4'h0, 1'b1);

        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
        end
        applyStimulus(1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkOutput("scoreboard_drained", sbQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
